// File: rtl/avalon_sdram_responder.sv
// -----------------------------------------------------------------------------
// avalon_sdram_responder
//   Avalon-MM slave memory model standing in for SDRAM behind the master port
//   of the DMA-style accelerators. Inserts a fixed waitrequest stall before
//   every command, returns reads after a fixed pipelined latency through
//   readdatavalid, and bounds the number of accepted-but-unreturned reads.
//
// Parameters
//   ADDR_W       word-address bits, memory depth = 2**ADDR_W 32-bit words
//   WAIT_CYCLES  waitrequest-high cycles before each command is accepted
//   READ_LATENCY cycles from read acceptance to readdatavalid (>= 1)
//   MAX_PENDING  maximum outstanding reads (>= 1)
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            asynchronous active-high reset
//   address        byte address, word index = address[ADDR_W+1:2]
//   read / write   command strobes, held stable while waitrequest is high
//   writedata      write data
//   waitrequest    high = command not accepted this cycle
//   readdata       read data, zero unless readdatavalid
//   readdatavalid  one-cycle pulse per returned read word
//   proto_err      sticky protocol-error flag, cleared only by rst
// -----------------------------------------------------------------------------
module avalon_sdram_responder #(
  parameter int ADDR_W       = 10,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        proto_err
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = $clog2(WAIT_CYCLES + 2);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                proto_err_q;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic                vld_q [READ_LATENCY];
  logic [31:0]         dat_q [READ_LATENCY];
  logic [31:0]         mem   [DEPTH];

  logic              cmd, is_wr, is_rd, room, accept, rd_acc, wr_acc, misaligned;
  logic [ADDR_W-1:0] idx;

  // Bits above the word index alias onto the same memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:ADDR_W+2];

  assign cmd        = read | write;
  assign is_wr      = write;            // read&write together is a write
  assign is_rd      = read & ~write;
  assign idx        = address[ADDR_W+1:2];
  assign misaligned = |address[1:0];

  // A read returning this cycle frees its slot for a read accepted now.
  assign room = is_wr | (pending_q < PEND_W'(MAX_PENDING)) | readdatavalid;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    waitrequest = 1'b0;
    unique case (state_q)
      IDLE:    waitrequest = cmd & ((WAIT_CYCLES != 0) | ~room);
      STALL:   waitrequest = cmd & ((cnt_q < CNT_W'(WAIT_CYCLES)) | ~room);
      default: waitrequest = 1'b0;
    endcase
  end

  assign accept = cmd & ~waitrequest;
  assign rd_acc = accept & is_rd;
  assign wr_acc = accept & is_wr;

  // NOTE: sequential state is updated with <= only, so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd && waitrequest) begin
            state_q <= STALL;
            cnt_q   <= CNT_W'(1);
          end
        end
        STALL: begin
          if (!cmd) begin
            // Master withdrew a stalled command.
            proto_err_q <= 1'b1;
            state_q     <= IDLE;
          end else if (accept) begin
            state_q <= IDLE;
          end else if (cnt_q < CNT_W'(WAIT_CYCLES)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (accept && (misaligned || (read && write))) proto_err_q <= 1'b1;
    end
  end

  // NOTE: the memory array has no reset; contents survive rst like real SDRAM
  // and this keeps it mappable onto RAM blocks.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[idx] <= writedata;
  end

  // Fixed-latency return pipeline; data lanes are zero when their valid is low
  // so readdata reads zero outside readdatavalid without extra gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc;
      dat_q[0] <= rd_acc ? mem[idx] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign readdata      = dat_q[READ_LATENCY-1];
  assign proto_err     = proto_err_q;

  always_comb begin
    pending_d = pending_q;
    if (rd_acc && !readdatavalid)      pending_d = pending_q + PEND_W'(1);
    else if (!rd_acc && readdatavalid) pending_d = pending_q - PEND_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

endmodule

// File: tb/tb_avalon_sdram_responder.sv
// -----------------------------------------------------------------------------
// tb_avalon_sdram_responder
//   Two responder configurations run side by side:
//     cfg0: WAIT_CYCLES=1, READ_LATENCY=2, MAX_PENDING=4
//     cfg1: WAIT_CYCLES=0, READ_LATENCY=4, MAX_PENDING=2
//   Each is driven with directed and random traffic and compared every cycle
//   against a transaction-level model: a word array, a queue of pending
//   returns tagged with their due cycle, and a count of cycles the current
//   command has been held.
// -----------------------------------------------------------------------------
module tb_avalon_sdram_responder;

  localparam int AW = 10;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int W = (g == 0) ? 1 : 0;
    localparam int L = (g == 0) ? 2 : 4;
    localparam int P = (g == 0) ? 4 : 2;

    logic        rst, read, write, waitrequest, readdatavalid, proto_err;
    logic [31:0] address, writedata, readdata;

    logic [31:0] mem_m [2**AW];
    ret_t        q [$];
    int          held   = 0;
    int          cyc    = 0;
    logic        perr_m = 1'b0;
    logic        fin    = 1'b0;

    avalon_sdram_responder #(
      .ADDR_W      (AW),
      .WAIT_CYCLES (W),
      .READ_LATENCY(L),
      .MAX_PENDING (P)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .address      (address),
      .read         (read),
      .write        (write),
      .writedata    (writedata),
      .waitrequest  (waitrequest),
      .readdata     (readdata),
      .readdatavalid(readdatavalid),
      .proto_err    (proto_err)
    );

    // One bus cycle: compare at the falling edge, then advance the model.
    task automatic step(output logic acc);
      logic cmd, due, room;
      int   idx;
      ret_t r;
      @(negedge clk);
      cmd  = read | write;
      due  = (q.size() > 0) && (q[0].due == cyc);
      room = write || (q.size() < P) || due;
      acc  = cmd && (held >= W) && room;
      check($sformatf("cfg%0d waitrequest c%0d", g, cyc), 32'(waitrequest), 32'(cmd && !acc));
      check($sformatf("cfg%0d readdatavalid c%0d", g, cyc), 32'(readdatavalid), 32'(due));
      check($sformatf("cfg%0d readdata c%0d", g, cyc), readdata, due ? q[0].data : 32'h0);
      check($sformatf("cfg%0d proto_err c%0d", g, cyc), 32'(proto_err), 32'(perr_m));
      if (due) void'(q.pop_front());
      idx = int'(address[AW+1:2]);
      if (acc) begin
        if (write) begin
          mem_m[idx] = writedata;
          if (read) perr_m = 1'b1;
        end else begin
          r.due  = cyc + L;
          r.data = mem_m[idx];
          q.push_back(r);
        end
        if (address[1:0] != 2'b00) perr_m = 1'b1;
        held = 0;
      end else if (cmd) begin
        held++;
      end else begin
        if (held > 0) perr_m = 1'b1;
        held = 0;
      end
      cyc++;
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int n);
      logic acc;
      read  = 1'b0;
      write = 1'b0;
      repeat (n) step(acc);
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      logic acc;
      acc       = 1'b0;
      read      = rd;
      write     = wr;
      address   = a;
      writedata = d;
      for (int i = 0; i < 64 && !acc; i++) step(acc);
      check($sformatf("cfg%0d accept within bound", g), 32'(acc), 32'd1);
      read  = 1'b0;
      write = 1'b0;
    endtask

    task automatic rand_op(input bit errs);
      int          k, idx;
      logic [1:0]  low;
      logic [31:0] a;
      logic        both;
      k    = $urandom_range(0, 9);
      idx  = $urandom_range(0, 15);
      low  = (errs && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      both = errs && ($urandom_range(0, 7) == 0);
      a    = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'(low);
      if (k < 3)      idle(1);
      else if (k < 7) issue(1'b1, both, a, $urandom);
      else            issue(1'b0, 1'b1, a, $urandom);
    endtask

    initial begin
      logic acc;
      rst       = 1'b1;
      read      = 1'b0;
      write     = 1'b0;
      address   = '0;
      writedata = '0;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("cfg%0d rst waitrequest", g), 32'(waitrequest), 32'd0);
      check($sformatf("cfg%0d rst readdatavalid", g), 32'(readdatavalid), 32'd0);
      check($sformatf("cfg%0d rst readdata", g), readdata, 32'd0);
      check($sformatf("cfg%0d rst proto_err", g), 32'(proto_err), 32'd0);
      rst = 1'b0;
      idle(10);

      // Initialise the working set so every read returns known data.
      for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 32'(i) << 2, $urandom);

      issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
      issue(1'b1, 1'b0, 32'h10, 32'h0);
      issue(1'b0, 1'b1, 32'h0000_1004, 32'h55);
      issue(1'b1, 1'b0, 32'h0000_0004, 32'h0);
      issue(1'b1, 1'b0, 32'h0, 32'h0);
      issue(1'b1, 1'b0, 32'h4, 32'h0);
      issue(1'b1, 1'b0, 32'h8, 32'h0);
      idle(L + 2);

      repeat (300) rand_op(1'b0);
      idle(L + 2);

      // Protocol errors: misaligned read, read&write, withdrawn stalled read.
      issue(1'b1, 1'b0, 32'h6, 32'h0);
      issue(1'b1, 1'b1, 32'h20, 32'h1234);
      issue(1'b1, 1'b0, 32'h20, 32'h0);
      idle(L + 2);
      repeat (P) issue(1'b1, 1'b0, 32'h0, 32'h0);
      read    = 1'b1;
      address = 32'h8;
      step(acc);
      idle(L + 2);
      repeat (100) rand_op(1'b1);
      idle(L + 2);

      // Reset one cycle after a read is accepted: the return must vanish.
      issue(1'b1, 1'b0, 32'h10, 32'h0);
      #2 rst = 1'b1;
      #1;
      check($sformatf("cfg%0d async rst waitrequest", g), 32'(waitrequest), 32'd0);
      check($sformatf("cfg%0d async rst readdatavalid", g), 32'(readdatavalid), 32'd0);
      check($sformatf("cfg%0d async rst readdata", g), readdata, 32'd0);
      check($sformatf("cfg%0d async rst proto_err", g), 32'(proto_err), 32'd0);
      q.delete();
      held   = 0;
      perr_m = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      idle(L + 3);
      issue(1'b0, 1'b1, 32'h40, 32'hCAFE_0040);
      issue(1'b1, 1'b0, 32'h40, 32'h0);
      idle(L + 2);
      repeat (50) rand_op(1'b0);
      idle(L + 2);
      fin = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin) && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    check("run completes", 32'(g_cfg[0].fin && g_cfg[1].fin), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
